// File: rtl/axis_pkg.sv
// Shared AXI-Stream types for the packet framer: beat layout, FSM states and
// a byte-masking helper used by the optional trailer checksum.
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 4;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axis_beat_t;

  typedef enum logic {
    S_DATA    = 1'b0,
    S_TRAILER = 1'b1
  } framer_state_t;

  // Zero every byte lane whose tkeep bit is clear.
  function automatic logic [AXIS_DATA_W-1:0] keep_mask(
    input logic [AXIS_DATA_W-1:0] data,
    input logic [AXIS_KEEP_W-1:0] keep
  );
    logic [AXIS_DATA_W-1:0] masked;
    masked = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++) begin
      masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry skid buffer over axis_beat_t. All outputs, including the
// upstream ready, come straight from flops so out_ready never reaches in_ready.
module axis_skid_buf
  import axis_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  axis_beat_t in_beat,
  input  logic       in_valid,
  output logic       in_ready,
  output axis_beat_t out_beat,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [1:0] occ;
  logic [1:0] occ_next;
  axis_beat_t head;
  axis_beat_t skid;
  logic       in_fire;
  logic       out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_beat = head;

  // NOTE: the default assignment before the case keeps this block free of latches.
  always_comb begin
    occ_next = occ;
    case ({in_fire, out_fire})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // head drives the output port; skid only fills when head is stalled.
  // NOTE: non-blocking assignments let every flop sample the pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: payload flops are reset too, so a discarded beat never lingers on m_axis.
      occ       <= 2'd0;
      head      <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      occ       <= occ_next;
      out_valid <= (occ_next != 2'd0);
      in_ready  <= (occ_next != 2'd2);
      case (occ)
        2'd0: begin
          if (in_fire) head <= in_beat;
        end
        2'd1: begin
          if (in_fire && out_fire)  head <= in_beat;
          else if (in_fire)         skid <= in_beat;
        end
        2'd2: begin
          if (out_fire) head <= skid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_pkt_framer.sv
// Re-frames a 32-bit AXI-Stream into packets of at most PKT_LEN beats.
// Define AXIS_FRAMER_CHKSUM_EN to append an XOR checksum trailer to each packet.
module axis_pkt_framer
  import axis_pkg::*;
#(
  parameter int PKT_LEN = 256,
  parameter int CNT_W   = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [15:0]            beat_count
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  axis_beat_t buf_in;
  axis_beat_t buf_out;
  logic       buf_in_valid;
  logic       buf_ready;
  logic       accept;
  logic       framed_last;

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign framed_last = s_axis_tlast | (beat_count == LAST_IDX);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_count <= 16'd0;
    end else if (accept) begin
      beat_count <= framed_last ? 16'd0 : beat_count + 16'd1;
    end
  end

`ifdef AXIS_FRAMER_CHKSUM_EN
  framer_state_t          state;
  logic [AXIS_DATA_W-1:0] acc;

  // The last data beat is folded into acc on the same edge that enters S_TRAILER,
  // so the trailer reads a complete checksum straight from the register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= S_DATA;
      acc   <= '0;
    end else begin
      case (state)
        S_DATA: begin
          if (accept) begin
            acc <= acc ^ keep_mask(s_axis_tdata, s_axis_tkeep);
            if (framed_last) state <= S_TRAILER;
          end
        end
        S_TRAILER: begin
          if (buf_ready) begin
            acc   <= '0;
            state <= S_DATA;
          end
        end
        default: state <= S_DATA;
      endcase
    end
  end

  always_comb begin
    buf_in       = '0;
    buf_in_valid = 1'b0;
    if (state == S_TRAILER) begin
      buf_in_valid = 1'b1;
      buf_in.tdata = acc;
      buf_in.tkeep = '1;
      buf_in.tlast = 1'b1;
    end else begin
      buf_in_valid = s_axis_tvalid;
      buf_in.tdata = s_axis_tdata;
      buf_in.tkeep = s_axis_tkeep;
      buf_in.tlast = 1'b0;
    end
  end

  // Both terms are flops; upstream is held off while the trailer is pushed.
  assign s_axis_tready = buf_ready & (state == S_DATA);
`else
  assign buf_in_valid  = s_axis_tvalid;
  assign buf_in        = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: framed_last};
  assign s_axis_tready = buf_ready;
`endif

  axis_skid_buf u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_beat   (buf_in),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_ready),
    .out_beat  (buf_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign m_axis_tdata = buf_out.tdata;
  assign m_axis_tkeep = buf_out.tkeep;
  assign m_axis_tlast = buf_out.tlast;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench for axis_pkt_framer: drivers push expected beats, a monitor
// pops and compares every output handshake and checks stall stability.
`timescale 1ns/1ps
module tb_axis_pkt_framer;
  import axis_pkg::*;

`ifdef AXIS_FRAMER_CHKSUM_EN
  localparam int P = 2;
`else
  localparam int P = 4;
`endif
  localparam int CNT_W = 32;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [CNT_W-1:0] pkt_count;
  logic [15:0] beat_count;

  axis_pkt_framer #(.PKT_LEN(P), .CNT_W(CNT_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_count     (pkt_count),
    .beat_count    (beat_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  axis_beat_t exp_q[$];
  logic       in_rst   = 1'b1;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  time        t_acc;
  logic       prev_stall = 1'b0;
  axis_beat_t prev_beat;
  axis_beat_t got;
  axis_beat_t want;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic axis_beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return '{tdata: d, tkeep: k, tlast: l};
  endfunction

  // Downstream ready changes just after the rising edge, never near a sample point.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: a beat seen valid&ready at the falling edge is taken on the next rise.
  initial begin
    forever begin
      @(negedge aclk);
      got = mk(m_axis_tdata, m_axis_tkeep, m_axis_tlast);
      if (in_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(m_axis_tvalid), 64'd1);
          check("stall_beat_held", 64'(got), 64'(prev_beat));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no output", got);
          end else begin
            want = exp_q.pop_front();
            check("out_beat", 64'(got), 64'(want));
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = got;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input axis_beat_t exp);
    int n;
    n = 0;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tready stayed 0, expected 1 for data 0x%08h", d);
      s_axis_tvalid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge aclk);
    t_acc = $time;
  endtask

  task automatic idle();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic do_reset(input int cycles);
    in_rst = 1'b1;
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (cycles) @(negedge aclk);
    check("rst_tready",  64'(s_axis_tready), 64'd0);
    check("rst_tvalid",  64'(m_axis_tvalid), 64'd0);
    check("rst_tdata",   64'(m_axis_tdata),  64'd0);
    check("rst_tkeep",   64'(m_axis_tkeep),  64'd0);
    check("rst_tlast",   64'(m_axis_tlast),  64'd0);
    check("rst_pkt_cnt", 64'(pkt_count),     64'd0);
    check("rst_beat_cnt", 64'(beat_count),   64'd0);
    exp_q.delete();
    aresetn = 1'b1;
    @(negedge aclk);
    check("tready_after_rst", 64'(s_axis_tready), 64'd1);
    in_rst = 1'b0;
  endtask

  initial begin
    time t0;
    int  cnt;
    logic [31:0] d;
    logic [3:0]  k;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    t0  = 0;
    cnt = 0;
    do_reset(2);

`ifdef AXIS_FRAMER_CHKSUM_EN
    // Packet 1: trailer = F0F0F0F0 ^ 0F0F00FF = FFFFF00F.
    send(32'hF0F0F0F0, 4'hF, 1'b0, mk(32'hF0F0F0F0, 4'hF, 1'b0));
    send(32'h0F0F00FF, 4'hF, 1'b0, mk(32'h0F0F00FF, 4'hF, 1'b0));
    exp_q.push_back(mk(32'hFFFFF00F, 4'hF, 1'b1));
    idle();
    check("trailer_tready_low", 64'(s_axis_tready), 64'd0);
    check("trailer_beat_cnt", 64'(beat_count), 64'd0);
    @(negedge aclk);
    check("after_trailer_tready", 64'(s_axis_tready), 64'd1);
    // Packet 2: masked 00003344 ^ AABBCCDD = AABBFF99.
    send(32'h11223344, 4'h3, 1'b0, mk(32'h11223344, 4'h3, 1'b0));
    send(32'hAABBCCDD, 4'hF, 1'b0, mk(32'hAABBCCDD, 4'hF, 1'b0));
    exp_q.push_back(mk(32'hAABBFF99, 4'hF, 1'b1));
    idle();
    drain();
    check("chk_pkt_count", 64'(pkt_count), 64'd2);
`else
    // Continuous burst of 10 beats, tlast forced on beats 4 and 8.
    for (int i = 1; i <= 10; i++) begin
      send(32'(i), 4'hF, 1'b0, mk(32'(i), 4'hF, (i == 4) || (i == 8)));
      if (i == 1) t0 = t_acc;
    end
    idle();
    check("burst_accept_span", 64'(t_acc - t0), 64'd90);
    check("burst_last_visible", 64'(m_axis_tvalid), 64'd1);
    check("burst_last_data", 64'(m_axis_tdata), 64'hA);
    check("burst_pkt_count", 64'(pkt_count), 64'd2);
    check("burst_beat_count", 64'(beat_count), 64'd2);
    drain();

    // Short packet from upstream tlast, then a full 4-beat packet.
    do_reset(1);
    send(32'h10, 4'hF, 1'b0, mk(32'h10, 4'hF, 1'b0));
    send(32'h11, 4'h3, 1'b1, mk(32'h11, 4'h3, 1'b1));
    send(32'h12, 4'hF, 1'b0, mk(32'h12, 4'hF, 1'b0));
    send(32'h13, 4'h1, 1'b0, mk(32'h13, 4'h1, 1'b0));
    send(32'h14, 4'hF, 1'b0, mk(32'h14, 4'hF, 1'b0));
    send(32'h15, 4'hF, 1'b0, mk(32'h15, 4'hF, 1'b1));
    idle();
    drain();
    check("short_pkt_count", 64'(pkt_count), 64'd2);
    check("short_beat_count", 64'(beat_count), 64'd0);

    // Downstream stall: two beats fill the skid, then upstream ready drops.
    rdy_mode = 2;
    repeat (2) @(negedge aclk);
    send(32'h20, 4'hF, 1'b0, mk(32'h20, 4'hF, 1'b0));
    send(32'h21, 4'hF, 1'b0, mk(32'h21, 4'hF, 1'b0));
    idle();
    check("stall_tready_low", 64'(s_axis_tready), 64'd0);
    check("stall_head_data", 64'(m_axis_tdata), 64'h20);
    check("stall_beat_count", 64'(beat_count), 64'd2);
    repeat (3) @(negedge aclk);
    rdy_mode = 0;
    send(32'h22, 4'hF, 1'b0, mk(32'h22, 4'hF, 1'b0));
    send(32'h23, 4'hF, 1'b0, mk(32'h23, 4'hF, 1'b1));
    idle();
    drain();
    check("stall_pkt_count", 64'(pkt_count), 64'd3);

    // Reset with two beats buffered mid-packet: they must never appear.
    rdy_mode = 2;
    repeat (2) @(negedge aclk);
    send(32'h30, 4'hF, 1'b0, mk(32'h30, 4'hF, 1'b0));
    send(32'h31, 4'hF, 1'b0, mk(32'h31, 4'hF, 1'b0));
    idle();
    check("pre_rst_beat_count", 64'(beat_count), 64'd2);
    do_reset(1);
    rdy_mode = 0;
    send(32'h40, 4'hF, 1'b0, mk(32'h40, 4'hF, 1'b0));
    send(32'h41, 4'hF, 1'b0, mk(32'h41, 4'hF, 1'b0));
    send(32'h42, 4'hF, 1'b0, mk(32'h42, 4'hF, 1'b0));
    send(32'h43, 4'hF, 1'b0, mk(32'h43, 4'hF, 1'b1));
    idle();
    drain();
    check("post_rst_pkt_count", 64'(pkt_count), 64'd1);
    check("post_rst_beat_count", 64'(beat_count), 64'd0);

    // 1000 beats with random upstream gaps and random downstream ready.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      d = $urandom;
      k = 4'($urandom);
      send(d, k, 1'b0, mk(d, k, cnt == P - 1));
      cnt = (cnt == P - 1) ? 0 : cnt + 1;
    end
    idle();
    rdy_mode = 0;
    drain();
    check("rand_pkt_count", 64'(pkt_count), 64'd251);
    check("rand_beat_count", 64'(beat_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_pkt_framer.md
Name: axis_pkt_framer

Overview:
- Stream stage placed directly downstream of the XOR stage and upstream of the DMA S2MM slave port.
- Re-frames the processed 32-bit stream into packets of at most PKT_LEN beats by forcing tlast.
- Registers all outputs behind a 2-entry skid buffer, so downstream backpressure never creates a combinational path to s_axis_tready.
- Exposes packet and beat counters for software status.

Parameters:
- PKT_LEN, 256: maximum beats per output packet; legal range 1..65535.
- CNT_W, 32: width of the pkt_count status counter.

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  32  input data
- s_axis_tkeep  in  4  input byte enables
- s_axis_tlast  in  1  upstream end-of-packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- m_axis_tdata  out  32  output data
- m_axis_tkeep  out  4  output byte enables
- m_axis_tlast  out  1  output end-of-packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- pkt_count  out  CNT_W  number of output packets completed, i.e. beats with tlast accepted downstream
- beat_count  out  16  beats accepted into the current input packet

Behaviour:
- Reset: when aresetn=0 at a clock edge, the following are forced low/zero:
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  - pkt_count, beat_count, skid contents, FSM state
  - s_axis_tready is 0 during reset and 1 on the first cycle after reset deasserts.
- Reset mid-packet discards the partial packet and any buffered beats. No tlast is emitted for the discarded packet.
- Input handshake: a beat is accepted when s_axis_tvalid & s_axis_tready.
- s_axis_tready is registered, equal to "skid buffer holds fewer than 2 entries after this cycle".
- Output handshake: m_axis_tvalid must not drop, and m_axis_tdata/tkeep/tlast must not change, while m_axis_tvalid=1 & m_axis_tready=0.
- Latency: an accepted beat appears on m_axis the next cycle if the output register is empty or being drained.
- Throughput: 1 beat/cycle sustained with m_axis_tready held at 1.
- Skid buffer behaviour:
  - Occupancy 0/1/2.
  - Simultaneous accept and drain keeps occupancy unchanged.
  - Occupancy 2 forces s_axis_tready=0 next cycle.
  - Beat order is always preserved.
- Framing:
  - beat_count increments on each accepted beat.
  - The stored tlast = s_axis_tlast | (beat_count == PKT_LEN-1).
  - beat_count returns to 0 on the accepted beat whose stored tlast=1.
- Upstream tlast earlier than PKT_LEN passes through and restarts the count, producing a short packet.
- tkeep passes unchanged; partial tkeep on non-last beats is forwarded without checking.
- pkt_count increments on m_axis_tvalid & m_axis_tready & m_axis_tlast. It wraps modulo 2^CNT_W.
- PKT_LEN=1: every beat carries tlast.

Optional Feature:
- Macro: AXIS_FRAMER_CHKSUM_EN.
- When defined, a 2-state FSM is added: S_DATA and S_TRAILER.
  - In S_DATA, a running 32-bit XOR of tdata is kept over all beats of the packet, with bytes with tkeep=0 masked to 0.
  - A framed last beat is stored with tlast=0, and the FSM enters S_TRAILER.
  - In S_TRAILER, s_axis_tready=0. One trailer beat is pushed with tdata=accumulated XOR, tkeep=4'hF, tlast=1.
  - The accumulator clears, and the FSM returns to S_DATA once the trailer enters the skid buffer.
  - Packets are therefore 1 beat longer than their data length. pkt_count counts trailer-terminated packets.
- When not defined, there is no FSM, no accumulator and no trailer; behaviour is exactly as described above.

Decomposition:
- Package axis_pkg holds:
  - AXIS_DATA_W=32 and AXIS_KEEP_W=4;
  - a packed struct axis_beat_t {tdata, tkeep, tlast};
  - the FSM state enum framer_state_t {S_DATA, S_TRAILER}.
- One sub-module: axis_skid_buf, a generic 2-entry registered buffer over axis_beat_t with registered ready. The framing counter and FSM stay in the top.

Test Plan:
- PKT_LEN=4, 10 continuous beats 0x1..0xA, m_axis_tready=1 -> output 1 beat/cycle starting 1 cycle after the first accept; tlast on 0x4 and 0x8; pkt_count=2; beat_count=2.
- PKT_LEN=4, upstream tlast on beat 2 of 0x10,0x11, then 4 beats -> tlast on 0x11 and on the 4th following beat; pkt_count=2.
- m_axis_tready=0 for 5 cycles during a stream -> at most 2 beats buffered, s_axis_tready=0 after the 2nd, m_axis signals stable; no loss or duplication after release.
- aresetn=0 for 1 cycle mid-packet (beat_count=2) -> all outputs 0, next packet starts at beat_count=0, and tlast lands after PKT_LEN new beats.
- Random valid/ready toggling, 1000 beats -> output sequence equals input sequence, with a tlast every PKT_LEN beats.
- AXIS_FRAMER_CHKSUM_EN, PKT_LEN=2, beats 0xF0F0F0F0, 0x0F0F00FF (tkeep=4'hF) -> 3 output beats, the 3rd being 0xFFFFF00F with tlast=1; s_axis_tready=0 while the trailer is pushed.
